// File: rtl/lime_mem_arbiter.sv
// Two-port arbiter in front of lime's unified memory: serialises CPU and loader
// accesses through a fixed-latency memory, one access in flight at a time.
module lime_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 2,
    parameter int MAX_GRANT = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] MAXG   = 3'(MAX_GRANT);
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = loader owns the current access
    logic              we_q, we_d;
    logic [2:0]        streak_q, streak_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ldr_ack_q, ldr_ack_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        streak_d    = streak_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    // Loader has priority until it has starved a waiting CPU MAX_GRANT times
                    if (ldr_req && (!cpu_req || streak_q < MAXG)) begin
                        owner_d     = 1'b1;
                        we_d        = ldr_we;
                        mem_addr_d  = ldr_addr;
                        mem_wdata_d = ldr_wdata;
                        streak_d    = cpu_req ? streak_q + 3'd1 : 3'd0;
                    end else begin
                        owner_d     = 1'b0;
                        we_d        = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        streak_d    = 3'd0;
                    end
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    mem_we_d = we_d;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d   = DONE;
                    cpu_ack_d = ~owner_q;
                    ldr_ack_d = owner_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d   = mem_rdata;
                    state_d   = DONE;
                    cpu_ack_d = ~owner_q;
                    ldr_ack_d = owner_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            streak_q    <= 3'd0;
            cnt_q       <= 3'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign ldr_rdata = rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
